// File: rtl/sum_bcd_pkg.sv
// -----------------------------------------------------------------------------
// sum_bcd_pkg
// Shared types and constants for the sequential sum-to-BCD / 7-segment block.
//   state_e    : converter FSM states (IDLE, SHIFT)
//   SEG_DIGIT  : active-low {g..a} segment patterns for digits 0..9
//   SEG_BLANK  : all segments off
//   dd_step    : one double-dabble iteration (add-3 adjust, then shift left 1)
// -----------------------------------------------------------------------------
package sum_bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  // Add 3 to a BCD nibble that is 5 or more so the following doubling
  // carries correctly into the next decimal digit. Inputs here never exceed 9,
  // so the result always fits in four bits.
  function automatic logic [3:0] add3_ge5(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // One iteration: adjust both scratch nibbles, then shift the scratch left by
  // one with the next binary bit entering at the LSB. The top bit shifted out
  // is always zero for inputs up to 63.
  function automatic logic [7:0] dd_step(input logic [7:0] scr, input logic bit_in);
    logic [7:0] adj;
    adj = {add3_ge5(scr[7:4]), add3_ge5(scr[3:0])};
    return (adj << 1) | 8'(bit_in);
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// -----------------------------------------------------------------------------
// seg7_dec
// Combinational BCD digit to active-low 7-segment pattern, bit order {g..a}.
// Codes above 9 cannot occur in normal operation and show a blank display.
//   digit : in  4  BCD digit
//   seg   : out 7  active-low segment pattern
// -----------------------------------------------------------------------------
module seg7_dec
  import sum_bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (digit <= 4'd9) begin
      seg = SEG_DIGIT[digit];
    end
  end

endmodule

// File: rtl/sum_bcd_7seg_seq.sv
// -----------------------------------------------------------------------------
// sum_bcd_7seg_seq
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with
// registered 7-segment outputs for the tens and ones displays of the adder sum.
//
// Build option: define LEADING_ZERO_BLANK_EN to blank OUT10 whenever the tens
// digit is zero (also at reset). BCD is unaffected by this option.
//
// Ports
//   CLK    in   1      rising-edge clock
//   RST_N  in   1      asynchronous active-low reset
//   START  in   1      request conversion of BIN; only sampled in IDLE
//   BIN    in   BIN_W  binary value to convert, sampled with START
//   BUSY   out  1      conversion in progress
//   DONE   out  1      one-cycle pulse when BCD/OUT10/OUT1 are updated
//   BCD    out  8      {tens,ones} BCD result
//   OUT10  out  7      tens digit, active-low {g..a}
//   OUT1   out  7      ones digit, active-low {g..a}
// BIN_W must be 1..6 so the result fits in two BCD digits.
// -----------------------------------------------------------------------------
module sum_bcd_7seg_seq
  import sum_bcd_pkg::*;
#(
  parameter int BIN_W = 5
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [BIN_W-1:0] BIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [7:0]       BCD,
  output logic [6:0]       OUT10,
  output logic [6:0]       OUT1
);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] OUT10_RST = SEG_BLANK;
`else
  localparam logic [6:0] OUT10_RST = SEG_DIGIT[0];
`endif

  state_e           state_q, state_d;
  logic [BIN_W-1:0] bin_q,   bin_d;
  logic [7:0]       scr_q,   scr_d;
  logic [2:0]       cnt_q,   cnt_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [7:0]       bcd_q,   bcd_d;
  logic [6:0]       out10_q, out10_d;
  logic [6:0]       out1_q,  out1_d;

  // Scratch value after this cycle's iteration; on the final iteration it is
  // the finished BCD result, so the decoders look at it directly and their
  // patterns are captured on the same edge as BCD.
  logic [7:0] scr_shift;
  logic [6:0] seg_tens, seg_ones;

  assign scr_shift = dd_step(scr_q, bin_q[BIN_W-1]);

  seg7_dec u_seg_tens (.digit(scr_shift[7:4]), .seg(seg_tens));
  seg7_dec u_seg_ones (.digit(scr_shift[3:0]), .seg(seg_ones));

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    out10_d = out10_q;
    out1_d  = out1_q;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          bin_d   = BIN;
          scr_d   = 8'h00;
          cnt_d   = 3'(BIN_W);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bin_d = bin_q << 1;
        scr_d = scr_shift;
        if (cnt_q == 3'd1) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bcd_d   = scr_shift;
          out1_d  = seg_ones;
`ifdef LEADING_ZERO_BLANK_EN
          out10_d = (scr_shift[7:4] == 4'd0) ? SEG_BLANK : seg_tens;
`else
          out10_d = seg_tens;
`endif
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= 8'h00;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= 8'h00;
      out10_q <= OUT10_RST;
      out1_q  <= SEG_DIGIT[0];
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      out10_q <= out10_d;
      out1_q  <= out1_d;
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign BCD   = bcd_q;
  assign OUT10 = out10_q;
  assign OUT1  = out1_q;

endmodule
